// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1-style UART transmitter, LSB first, fixed clocks-per-bit divider.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_serializer: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state;
  logic [BAUD_W-1:0]    baud;
  logic [BIT_W-1:0]     bitc;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  logic baud_done;
  assign baud_done = (baud == BAUD_LAST);

  // Handshake flags are pure state decodes so tx_valid never reaches tx_ready.
  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      tx     <= 1'b1;
      baud   <= '0;
      bitc   <= '0;
      shift  <= '0;
`ifdef UART_TX_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      tx   <= 1'b1;
      baud <= '0;
      bitc <= '0;
      if (tx_valid) begin
        shift  <= tx_data;
        tx     <= 1'b0;
        state  <= S_START;
`ifdef UART_TX_PARITY_EN
        parity <= ^tx_data;
`endif
      end
    end else begin
      baud <= baud_done ? '0 : baud + 1'b1;
      if (baud_done) begin
        case (state)
          S_START: begin
            tx    <= shift[0];
            shift <= shift >> 1;
            bitc  <= '0;
            state <= S_DATA;
          end
          S_DATA: begin
            if (bitc == DATA_LAST) begin
              bitc  <= '0;
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bitc  <= bitc + 1'b1;
              tx    <= shift[0];
              shift <= shift >> 1;
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
`endif
          S_STOP: begin
            tx <= 1'b1;
            if (bitc == STOP_LAST) begin
              bitc  <= '0;
              state <= S_IDLE;
            end else begin
              bitc <= bitc + 1'b1;
            end
          end
          default: begin
            tx    <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
